// File: rtl/memmap_ctrl.sv
// Data-space controller: routes AVR core accesses to SRAM, a banked window or a small register file.
// Optional keyboard interrupt output enabled by defining MEMMAP_KBIRQ_EN.
module memmap_ctrl #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] WIN_BASE = 16'hF000,
  parameter int unsigned       WIN_BITS = 12,
  parameter int unsigned       BANK_W   = 8,
  parameter logic [ADDR_W-1:0] IO_BASE  = 16'h0020,
  parameter int unsigned       KB_DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [ADDR_W-1:0]          address,
  input  logic [7:0]                 data_o,
  input  logic                       wren,
  input  logic                       rden,
  output logic [7:0]                 data_i,
  input  logic [7:0]                 q_sram,
  input  logic [7:0]                 q_win,
  output logic                       we_sram,
  output logic                       we_win,
  output logic [BANK_W+WIN_BITS-1:0] win_address,
  output logic [BANK_W-1:0]          bank,
  output logic [7:0]                 cursor_x,
  output logic [7:0]                 cursor_y,
  input  logic                       kb_valid,
  input  logic [7:0]                 kb_data,
  output logic                       kb_ready,
  output logic                       kb_irq
);

  localparam int unsigned PW = $clog2(KB_DEPTH);
  localparam int unsigned CW = $clog2(KB_DEPTH + 1);
  localparam logic [ADDR_W-1:0] IO_HI = IO_BASE + ADDR_W'(4);

  typedef enum logic [1:0] {
    C_SRAM,
    C_WIN,
    C_REG
  } cls_t;

  cls_t          cls;
  cls_t          rd_cls;
  logic          is_reg;
  logic          is_win;
  logic [2:0]    off;
  logic          reg_wr;
  logic [7:0]    reg_rdata;
  logic [7:0]    rd_val;

  logic [7:0]    fifo [KB_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          push;
  logic          pop;
  logic          ovf_set;
  logic          ovf_clr;

  // Address decode; the register file wins over the window.
  always_comb begin
    is_reg = (address >= IO_BASE) && (address <= IO_HI);
    is_win = address[ADDR_W-1:WIN_BITS] == WIN_BASE[ADDR_W-1:WIN_BITS];
    off    = 3'(address - IO_BASE);
    cls    = C_SRAM;
    unique case (1'b1)
      is_reg:  cls = C_REG;
      is_win:  cls = C_WIN;
      default: cls = C_SRAM;
    endcase
  end

  assign reg_wr      = wren & is_reg;
  assign we_sram     = wren & (cls == C_SRAM);
  assign we_win      = wren & (cls == C_WIN);
  assign win_address = {bank, address[WIN_BITS-1:0]};

  assign full     = count == CW'(KB_DEPTH);
  assign empty    = count == '0;
  assign kb_ready = ~full;

  // A full FIFO still accepts a code when the head leaves in the same cycle.
  assign pop     = rden & is_reg & (off == 3'd4) & ~empty;
  assign push    = kb_valid & (~full | pop);
  assign ovf_set = kb_valid & full & ~pop;
  assign ovf_clr = reg_wr & (off == 3'd3) & data_o[2];

  // Register-file read value, sampled into the read pipeline every cycle.
  always_comb begin
    reg_rdata = 8'h00;
    case (off)
      3'd0:    reg_rdata = 8'(bank);
      3'd1:    reg_rdata = cursor_x;
      3'd2:    reg_rdata = cursor_y;
      3'd3:    reg_rdata = {5'b0, ovf, full, ~empty};
      3'd4:    reg_rdata = empty ? 8'h00 : fifo[rd_ptr];
      default: reg_rdata = 8'h00;
    endcase
  end

  // Writable control registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bank     <= '0;
      cursor_x <= '0;
      cursor_y <= '0;
    end else if (reg_wr) begin
      case (off)
        3'd0:    bank     <= BANK_W'(data_o);
        3'd1:    cursor_x <= data_o;
        3'd2:    cursor_y <= data_o;
        default: ;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until pushed.
  always_ff @(posedge clock) begin
    if (push) fifo[wr_ptr] <= kb_data;
  end

  // FIFO pointers, occupancy and sticky overflow; a new overflow beats a clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      ovf   <= ovf_set | (ovf & ~ovf_clr);
    end
  end

  // Read pipeline: capture class and register value to match RAM latency.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_cls <= C_REG;
      rd_val <= 8'h00;
    end else begin
      rd_cls <= cls;
      rd_val <= reg_rdata;
    end
  end

  // Return data mux selected by the captured class.
  always_comb begin
    data_i = rd_val;
    case (rd_cls)
      C_SRAM:  data_i = q_sram;
      C_WIN:   data_i = q_win;
      default: data_i = rd_val;
    endcase
  end

`ifdef MEMMAP_KBIRQ_EN
  logic irq_q;

  // Interrupt follows FIFO-not-empty or overflow, one cycle behind.
  always_ff @(posedge clock) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= ~empty | ovf;
  end

  assign kb_irq = irq_q;
`else
  assign kb_irq = 1'b0;
`endif

endmodule
